calc_sampler: RTL
=================

CALC_SAMPLER -- requirements
Module: calc_sampler

Interface
REQ-001 Parameter MAX_SHIFT, default 10, SHALL set the largest allowed window exponent.
REQ-002 clk_i  in  1  SHALL be the single block clock; all state changes on its rising edge.
REQ-003 reset_i  in  1  SHALL be an asynchronous, active-high reset.
REQ-004 enable_i  in  1  SHALL arm the sampler while high.
REQ-005 trig_i  in  1  SHALL be the sample strobe; each rising edge samples value_i.
REQ-006 value_i  in  32  SHALL be the signed value to sample (a CALC block output).
REQ-007 SHIFT  in  32  SHALL be the requested window exponent; window length is 2^SHIFT samples.
REQ-008 SHIFT_WSTB  in  1  SHALL be the one-cycle write strobe for SHIFT.
REQ-009 mean_o  out  32  SHALL be the signed window mean.
REQ-010 min_o  out  32  SHALL be the signed window minimum.
REQ-011 max_o  out  32  SHALL be the signed window maximum.
REQ-012 valid_o  out  1  SHALL be a one-cycle pulse marking new results.
REQ-013 count_o  out  32  SHALL count completed windows.
REQ-014 health_o  out  2  SHALL report status: 0 OK, 1 SHIFT clamped.

Function
REQ-015 FSM states SHALL be IDLE, ARMED, ACCUM and DONE.
REQ-016 IDLE->ARMED SHALL occur on the first cycle enable_i is high; this clears the accumulator, min/max and sample counter, and latches the effective shift.
REQ-017 Edge detection: trig_i high at cycle k and low at k-1 SHALL be an edge; level-high trig_i SHALL count once only.
REQ-018 ARMED->ACCUM SHALL occur on the first edge, with that sample taken.
REQ-019 Accumulation SHALL use a 48-bit signed sum; value_i is sign-extended; no overflow is possible for MAX_SHIFT<=10.
REQ-020 Min/max comparisons SHALL be signed; the first sample of a window loads both.
REQ-021 Sample registers SHALL update at cycle k+1 for an edge detected at cycle k.
REQ-022 When the sample count reaches 2^shift, the FSM SHALL enter DONE.
REQ-023 In DONE: mean_o = sum arithmetically shifted right by shift (rounds toward minus infinity), min_o and max_o are loaded, valid_o pulses, and count_o increments, all at cycle k+2 after the final edge.
REQ-024 DONE->ARMED SHALL occur after one cycle with the window statistics cleared, giving continuous windows.
REQ-025 An edge coincident with the DONE cycle SHALL be the first sample of the next window and SHALL NOT be lost.
REQ-026 shift=0 SHALL give one-sample windows with mean_o = value.
REQ-027 SHIFT_WSTB SHALL store the new value, which takes effect at the next ARMED entry only; an in-progress window is unaffected.
REQ-028 SHIFT > MAX_SHIFT SHALL be clamped to MAX_SHIFT and set health_o=1; health_o SHALL return to 0 on the next valid write.
REQ-029 Negative SHIFT (bit 31 set) SHALL be treated as greater than MAX_SHIFT.
REQ-030 enable_i low in any state SHALL force IDLE next cycle; a partial window is discarded, no valid_o is issued, and result outputs and count_o hold.
REQ-031 count_o SHALL wrap from 2^32-1 to 0.

Reset
REQ-032 reset_i SHALL immediately clear: state=IDLE, mean_o=min_o=max_o=0, valid_o=0, count_o=0, health_o=0, stored SHIFT=0, accumulator and edge history=0.
REQ-033 Reset mid-window SHALL discard the window; the first edge after reset release SHALL NOT be detected unless trig_i was low for at least one cycle.

Structure
REQ-034 Shared package calc_pkg SHALL hold: state encoding, MAX_SHIFT default, ACC_W=48, health codes.
REQ-035 Sub-module calc_window_stats SHALL hold the accumulator, min/max and sample counter, with clear/load/sample controls; the FSM and registers stay in calc_sampler.

Verification
REQ-036 SHIFT=2, edges with values 4,8,12,16 -> valid_o pulse 2 cycles after the 4th edge; mean_o=10, min_o=4, max_o=16, count_o=1.
REQ-037 SHIFT=1, values -5,-6 -> mean_o=-6 (0xFFFFFFFA), min_o=-6, max_o=-5.
REQ-038 SHIFT=1, continuous windows 1,3 then 5,7 where the edge for 5 coincides with the DONE cycle -> means 2 then 6, count_o=2.
REQ-039 SHIFT=12 write -> health_o=1; 1024 edges of value 7 -> mean_o=7; then SHIFT=3 write -> health_o=0.
REQ-040 SHIFT=2, 3 edges, then enable_i low -> no valid_o, outputs hold; re-enable plus 4 edges of value 2 -> mean_o=2.
REQ-041 reset_i asserted after 2 of 4 edges -> all outputs 0 immediately; trig_i held high across release -> no sample taken.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the windowed sampler: FSM encoding,
// accumulator width, default window exponent limit and health codes.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } calc_state_t;

  localparam int MAX_SHIFT_DEF = 10;
  localparam int ACC_W         = 48;

  localparam logic [1:0] HEALTH_OK      = 2'd0;
  localparam logic [1:0] HEALTH_CLAMPED = 2'd1;

endpackage

// File: rtl/calc_window_stats.sv
// Per-window running statistics: signed sum, min, max and a down-counter of
// samples still owed to the current window.
module calc_window_stats
  import calc_pkg::*;
#(
  parameter int MAX_SHIFT = MAX_SHIFT_DEF,
  parameter int SW        = $clog2(MAX_SHIFT + 1),
  parameter int CW        = MAX_SHIFT + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr_i,
  input  logic                    smp_i,
  input  logic [SW-1:0]           shift_i,
  input  logic signed [31:0]      value_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic signed [31:0]      min_o,
  output logic signed [31:0]      max_o,
  output logic [CW-1:0]           rem_o
);

  logic signed [ACC_W-1:0] sum_q;
  logic signed [31:0]      min_q;
  logic signed [31:0]      max_q;
  logic [CW-1:0]           rem_q;
  logic [CW-1:0]           win_len;
  logic signed [ACC_W-1:0] value_ext;

  assign win_len   = CW'(1) << shift_i;
  assign value_ext = {{(ACC_W-32){value_i[31]}}, value_i};

  // clr with smp loads the first sample of a fresh window
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sum_q <= '0;
      min_q <= '0;
      max_q <= '0;
      rem_q <= '0;
    end else if (clr_i) begin
      if (smp_i) begin
        sum_q <= value_ext;
        min_q <= value_i;
        max_q <= value_i;
        rem_q <= win_len - CW'(1);
      end else begin
        sum_q <= '0;
        min_q <= '0;
        max_q <= '0;
        rem_q <= win_len;
      end
    end else if (smp_i) begin
      sum_q <= sum_q + value_ext;
      if (value_i < min_q) min_q <= value_i;
      if (value_i > max_q) max_q <= value_i;
      rem_q <= rem_q - CW'(1);
    end
  end

  assign sum_o = sum_q;
  assign min_o = min_q;
  assign max_o = max_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/calc_sampler.sv
// Windowed sampler of a CALC output: on trigger edges collects 2^shift samples
// and publishes mean/min/max with a one-cycle valid pulse and a window count.
//
// state | meaning
// IDLE  | disabled; results and count hold
// ARMED | window cleared, waiting for its first edge
// ACCUM | collecting samples until the window is full
// DONE  | publish results, clear stats, take a coincident edge as next first
module calc_sampler
  import calc_pkg::*;
#(
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        trig_i,
  input  logic [31:0] value_i,
  input  logic [31:0] SHIFT,
  input  logic        SHIFT_WSTB,
  output logic [31:0] mean_o,
  output logic [31:0] min_o,
  output logic [31:0] max_o,
  output logic        valid_o,
  output logic [31:0] count_o,
  output logic [1:0]  health_o
);

  localparam int SW = $clog2(MAX_SHIFT + 1);
  localparam int CW = MAX_SHIFT + 1;

  calc_state_t             state_q, state_d;
  logic                    trig_q;
  logic                    trg_edge;
  logic [SW-1:0]           shift_q;
  logic [SW-1:0]           eff_shift_q;
  logic [SW-1:0]           shift_sel;
  logic                    st_clr;
  logic                    st_smp;
  logic                    done_load;
  logic signed [ACC_W-1:0] st_sum;
  logic signed [31:0]      st_min;
  logic signed [31:0]      st_max;
  logic [CW-1:0]           st_rem;

  assign trg_edge = trig_i & ~trig_q;

  calc_window_stats #(
    .MAX_SHIFT (MAX_SHIFT),
    .SW        (SW),
    .CW        (CW)
  ) u_stats (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (st_clr),
    .smp_i   (st_smp),
    .shift_i (shift_sel),
    .value_i (value_i),
    .sum_o   (st_sum),
    .min_o   (st_min),
    .max_o   (st_max),
    .rem_o   (st_rem)
  );

  // Window-opening states use the stored shift; a running window keeps its own
  always_comb begin
    state_d   = state_q;
    st_clr    = 1'b0;
    st_smp    = 1'b0;
    done_load = 1'b0;
    shift_sel = eff_shift_q;
    unique case (state_q)
      ST_IDLE: begin
        shift_sel = shift_q;
        if (enable_i) begin
          st_clr  = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (trg_edge) begin
          st_clr  = 1'b1;
          st_smp  = 1'b1;
          state_d = (eff_shift_q == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (trg_edge) begin
          st_smp = 1'b1;
          if (st_rem == CW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        shift_sel = shift_q;
        st_clr    = 1'b1;
        done_load = 1'b1;
        st_smp    = trg_edge;
        if (trg_edge) state_d = (shift_q == '0) ? ST_DONE : ST_ACCUM;
        else          state_d = ST_ARMED;
      end
    endcase
    if (!enable_i) begin
      state_d   = ST_IDLE;
      st_clr    = 1'b0;
      st_smp    = 1'b0;
      done_load = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      trig_q      <= 1'b0;
      shift_q     <= '0;
      eff_shift_q <= '0;
      health_o    <= HEALTH_OK;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_i;
      if (st_clr) eff_shift_q <= shift_sel;
      if (SHIFT_WSTB) begin
        if (SHIFT[31] || (SHIFT > 32'(MAX_SHIFT))) begin
          shift_q  <= SW'(MAX_SHIFT);
          health_o <= HEALTH_CLAMPED;
        end else begin
          shift_q  <= SW'(SHIFT);
          health_o <= HEALTH_OK;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mean_o  <= '0;
      min_o   <= '0;
      max_o   <= '0;
      valid_o <= 1'b0;
      count_o <= '0;
    end else begin
      valid_o <= done_load;
      if (done_load) begin
        mean_o  <= 32'(st_sum >>> eff_shift_q);
        min_o   <= st_min;
        max_o   <= st_max;
        count_o <= count_o + 32'd1;
      end
    end
  end

endmodule
